// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an 8-entry FIFO and sends them as UART frames.
// Frame: start(0), 8 data bits LSB first, [even parity], stop(1). Line idles high.
// Ports: clk, reset (async, active high), fifo_empty, fifo_dout[7:0] (1-cycle
// read latency) in; fifo_r_en, tx, busy, tx_done, frame_count[15:0] out.
// Param CLKS_PER_BIT (2..65535). Macro FIFO_UART_TX_PARITY_EN adds parity bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_r_en,
  output logic        tx,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  // tx_done is registered, so it is raised one cycle ahead.
  localparam logic [15:0] PRE  = 16'(CLKS_PER_BIT - 2);

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
`ifdef FIFO_UART_TX_PARITY_EN
  logic        par;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      par         <= 1'b0;
`endif
      fifo_r_en   <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      frame_count <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state     <= S_POP;
            fifo_r_en <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_POP: begin
          fifo_r_en <= 1'b0;
          state     <= S_LOAD;
        end
        S_LOAD: begin
          shift <= fifo_dout;
`ifdef FIFO_UART_TX_PARITY_EN
          par   <= ^fifo_dout;
`endif
          tx    <= 1'b0;
          cnt   <= '0;
          state <= S_START;
        end
        S_START: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= S_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx    <= par;
              state <= S_PARITY;
`else
              tx    <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            tx    <= 1'b1;
            state <= S_STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (cnt == LAST) begin
            cnt         <= '0;
            tx_done     <= 1'b0;
            frame_count <= frame_count + 16'd1;
            if (!fifo_empty) begin
              state     <= S_POP;
              fifo_r_en <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt     <= cnt + 16'd1;
            tx_done <= (cnt == PRE);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with a small FIFO model.
// Instance u_dut uses CLKS_PER_BIT=4, u_dut2 uses CLKS_PER_BIT=2.
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        empty1, empty2;
  logic [7:0]  dout1 = 8'h00;
  logic [7:0]  dout2 = 8'h00;
  logic        r_en1, r_en2;
  logic        tx1, tx2;
  logic        busy1, busy2;
  logic        done1, done2;
  logic [15:0] fc1, fc2;

  logic [7:0] mem1 [0:31];
  logic [7:0] mem2 [0:31];
  int wp1 = 0, rp1 = 0, wp2 = 0, rp2 = 0;

  int compared = 0;
  int mismatched = 0;
  int rpulses = 0;
  int rconsec = 0;
  int rempty = 0;
  logic prev1 = 1'b0;
  logic prev2 = 1'b0;

  always #5 clk = ~clk;

  assign empty1 = (wp1 == rp1);
  assign empty2 = (wp2 == rp2);

  fifo_uart_tx #(.CLKS_PER_BIT(4)) u_dut (
    .clk(clk), .reset(reset),
    .fifo_empty(empty1), .fifo_dout(dout1),
    .fifo_r_en(r_en1), .tx(tx1), .busy(busy1),
    .tx_done(done1), .frame_count(fc1)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .fifo_empty(empty2), .fifo_dout(dout2),
    .fifo_r_en(r_en2), .tx(tx2), .busy(busy2),
    .tx_done(done2), .frame_count(fc2)
  );

  always @(posedge clk) begin
    if (r_en1 && rp1 != wp1) begin
      dout1 <= mem1[rp1 % 32];
      rp1   <= rp1 + 1;
    end
    if (r_en2 && rp2 != wp2) begin
      dout2 <= mem2[rp2 % 32];
      rp2   <= rp2 + 1;
    end
  end

  always @(posedge clk) begin
    if (r_en1) rpulses = rpulses + 1;
    if ((r_en1 && prev1) || (r_en2 && prev2))
      rconsec = rconsec + 1;
    if ((r_en1 && wp1 == rp1) || (r_en2 && wp2 == rp2))
      rempty = rempty + 1;
    prev1 = r_en1;
    prev2 = r_en2;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [7:0] b);
    mem1[wp1 % 32] = b;
    wp1 = wp1 + 1;
  endtask

  task automatic push2(input logic [7:0] b);
    mem2[wp2 % 32] = b;
    wp2 = wp2 + 1;
  endtask

  function automatic logic txs(input int sel);
    return (sel != 0) ? tx2 : tx1;
  endfunction

  function automatic logic dns(input int sel);
    return (sel != 0) ? done2 : done1;
  endfunction

  // Waits for the start edge, then checks every cycle of the frame.
  // gap = high cycles seen before the start bit.
  task automatic frame(input int sel,
                       input logic [7:0] b,
                       input string tag,
                       output int gap);
    int cpb;
    int g;
    int m;
    int dc;
    bit got;
    logic last_done;
    logic eb [0:10];
    cpb = (sel != 0) ? 2 : 4;
    got = 0;
    g = 0;
    dc = 0;
    last_done = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (txs(sel) == 1'b0) got = 1;
      else g++;
    end
    gap = g;
    chk({tag, "_start_seen"}, 32'(got), 32'd1);
    if (got) begin
      eb[0] = 1'b0;
      for (int k = 0; k < 8; k++) eb[k+1] = b[k];
`ifdef FIFO_UART_TX_PARITY_EN
      eb[9]  = ^b;
      eb[10] = 1'b1;
`else
      eb[9]  = 1'b1;
      eb[10] = 1'b1;
`endif
      for (int k = 0; k < NB; k++) begin
        m = 0;
        for (int c = 0; c < cpb; c++) begin
          if (k > 0 || c > 0) @(negedge clk);
          if (txs(sel) === eb[k]) m++;
          if (dns(sel) === 1'b1) dc++;
          last_done = dns(sel);
        end
        chk($sformatf("%s_bit%0d", tag, k),
            32'(m), 32'(cpb));
      end
      chk({tag, "_done_cnt"}, 32'(dc), 32'd1);
      chk({tag, "_done_last"}, 32'(last_done), 32'd1);
    end
  endtask

  initial begin
    int g;
    int bad;
    int base;
    bit got;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx1), 32'd1);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_ren", 32'(r_en1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_fc", 32'(fc1), 32'd0);
    chk("rst_fc2", 32'(fc2), 32'd0);
    reset = 1'b0;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy1 !== 1'b0 || tx1 !== 1'b1 || r_en1 !== 1'b0)
        bad++;
    end
    chk("idle_hold", 32'(bad), 32'd0);
    chk("idle_no_pop", 32'(rpulses), 32'd0);

    base = rpulses;
    push1(8'hA5);
    frame(0, 8'hA5, "a5", g);
    @(negedge clk);
    chk("a5_rpulse", 32'(rpulses - base), 32'd1);
    chk("a5_fc", 32'(fc1), 32'd1);
    repeat (3) @(negedge clk);
    chk("a5_busy_low", 32'(busy1), 32'd0);
    chk("a5_tx_idle", 32'(tx1), 32'd1);

`ifdef FIFO_UART_TX_PARITY_EN
    push1(8'h07);
    frame(0, 8'h07, "p07", g);
    @(negedge clk);
    chk("p07_fc", 32'(fc1), 32'd2);
`endif

    reset = 1'b1;
    @(negedge clk);
    chk("rst2_fc", 32'(fc1), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    base = rpulses;
    push1(8'h01);
    push1(8'h80);
    push1(8'hFF);
    frame(0, 8'h01, "b01", g);
    frame(0, 8'h80, "b80", g);
    chk("gap1", 32'(g), 32'd2);
    frame(0, 8'hFF, "bff", g);
    chk("gap2", 32'(g), 32'd2);
    @(negedge clk);
    chk("burst_rpulse", 32'(rpulses - base), 32'd3);
    chk("burst_fc", 32'(fc1), 32'd3);
    repeat (3) @(negedge clk);
    chk("burst_busy_low", 32'(busy1), 32'd0);
    chk("burst_tx_idle", 32'(tx1), 32'd1);

    push1(8'h3C);
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (tx1 == 1'b0) got = 1;
    end
    chk("m3c_start_seen", 32'(got), 32'd1);
    repeat (17) @(negedge clk);
    chk("m3c_busy_pre", 32'(busy1), 32'd1);
    reset = 1'b1;
    #1;
    chk("m3c_tx_rst", 32'(tx1), 32'd1);
    chk("m3c_fc_rst", 32'(fc1), 32'd0);
    chk("m3c_busy_rst", 32'(busy1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    base = rpulses;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
    end
    chk("m3c_no_pop", 32'(rpulses - base), 32'd0);
    chk("m3c_idle", 32'(bad), 32'd0);

    push2(8'h55);
    frame(1, 8'h55, "c2", g);
    @(negedge clk);
    chk("c2_fc", 32'(fc2), 32'd1);
    repeat (3) @(negedge clk);
    chk("c2_busy_low", 32'(busy2), 32'd0);

    chk("ren_consec", 32'(rconsec), 32'd0);
    chk("ren_empty", 32'(rempty), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
